// File: rtl/proc_control.sv
// Step-sequenced control unit for the 8-register bus datapath.
// The only state is the T0..T3 step counter; every strobe is decoded from (step, IR, Run).
module dec3to8 (
  input  logic [2:0] W,
  input  logic       En,
  output logic [0:7] Y
);
  always_comb begin
    Y = '0;
    if (En) Y[W] = 1'b1;
  end
endmodule

module proc_control (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Run,
  input  logic [8:0] IR,
  output logic       IRin,
  output logic [0:7] Rin,
  output logic [0:7] Rout,
  output logic       DINout,
  output logic       Gout,
  output logic       Ain,
  output logic       Gin,
  output logic       AddSub,
  output logic       Done,
  output logic [1:0] Tstep
);
  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  logic [1:0] step_q, step_d;
  logic [2:0] op, rx, ry;
  logic       is_arith;
  logic       rin_en, rout_en;
  logic [2:0] rin_sel, rout_sel;
  logic       irin_c, dinout_c, gout_c, ain_c, gin_c, addsub_c, done_c;

  assign op       = IR[8:6];
  assign rx       = IR[5:3];
  assign ry       = IR[2:0];
  assign is_arith = (op == OP_ADD) || (op == OP_SUB);

  always_comb begin
    step_d   = step_q;
    irin_c   = 1'b0;
    dinout_c = 1'b0;
    gout_c   = 1'b0;
    ain_c    = 1'b0;
    gin_c    = 1'b0;
    addsub_c = 1'b0;
    done_c   = 1'b0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rin_sel  = rx;
    rout_sel = ry;
    case (step_q)
      T0: begin
        irin_c = Run;
        if (Run) step_d = T1;
      end
      T1: begin
        step_d = T0;
        case (op)
          OP_MV: begin
            rout_en = 1'b1;
            rin_en  = 1'b1;
            done_c  = 1'b1;
          end
          OP_MVI: begin
            dinout_c = 1'b1;
            rin_en   = 1'b1;
            done_c   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            rout_sel = rx;
            rout_en  = 1'b1;
            ain_c    = 1'b1;
            step_d   = T2;
          end
          default: done_c = 1'b1;
        endcase
      end
      T2: begin
        // An opcode that changed mid-instruction falls back to T0 silently.
        step_d = T0;
        if (is_arith) begin
          rout_en  = 1'b1;
          gin_c    = 1'b1;
          addsub_c = IR[6];
          step_d   = T3;
        end
      end
      default: begin
        step_d = T0;
        if (is_arith) begin
          gout_c = 1'b1;
          rin_en = 1'b1;
          done_c = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) step_q <= T0;
    else         step_q <= step_d;
  end

  dec3to8 u_rin_dec (
    .W  (rin_sel),
    .En (rin_en & Resetn),
    .Y  (Rin)
  );

  dec3to8 u_rout_dec (
    .W  (rout_sel),
    .En (rout_en & Resetn),
    .Y  (Rout)
  );

  // Reset masks every strobe combinationally so nothing leaks while held low.
  assign IRin   = irin_c   & Resetn;
  assign DINout = dinout_c & Resetn;
  assign Gout   = gout_c   & Resetn;
  assign Ain    = ain_c    & Resetn;
  assign Gin    = gin_c    & Resetn;
  assign AddSub = addsub_c & Resetn;
  assign Done   = done_c   & Resetn;
  assign Tstep  = step_q;
endmodule

// File: tb/tb_proc_control.sv
// Directed bench for proc_control: per-step strobe vectors plus a per-cycle bus monitor.
module tb_proc_control;
  logic       Clock = 1'b0;
  logic       Resetn, Run;
  logic [8:0] IR;
  logic       IRin, DINout, Gout, Ain, Gin, AddSub, Done;
  logic [0:7] Rin, Rout;
  logic [1:0] Tstep;

  int n_chk = 0;
  int n_fail = 0;

  proc_control dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .IR(IR),
    .IRin(IRin), .Rin(Rin), .Rout(Rout), .DINout(DINout), .Gout(Gout),
    .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .Done(Done), .Tstep(Tstep)
  );

  always #5 Clock = ~Clock;

  // Packed view, MSB first: IRin, Rin[0..7], Rout[0..7], DINout, Gout, Ain, Gin, AddSub, Done, Tstep.
  logic [24:0] obs;
  assign obs = {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done, Tstep};

  function automatic logic [24:0] ex(input logic irin, input logic [7:0] rin,
                                     input logic [7:0] rout, input logic din,
                                     input logic gout, input logic ain, input logic gin,
                                     input logic as, input logic done, input logic [1:0] t);
    return {irin, rin, rout, din, gout, ain, gin, as, done, t};
  endfunction

  // Bus-exclusivity and one-hot checks on every cycle.
  always @(negedge Clock) begin
    n_chk++;
    if (($countones(Rout) + DINout + Gout) > 1 || $countones(Rin) > 1 || (Ain + Gin) > 1) begin
      n_fail++;
      $display("FAIL bus_excl t=%0t Rout=%b DINout=%b Gout=%b Rin=%b Ain=%b Gin=%b",
               $time, Rout, DINout, Gout, Rin, Ain, Gin);
    end
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset;
    Resetn = 1'b0; Run = 1'b1; IR = 9'o012;
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      n_chk++;
      if (obs !== ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0)) begin
        n_fail++; $display("FAIL reset_edge%0d got %h exp %h", i, obs, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0));
      end
    end
    Resetn = 1'b1; Run = 1'b0;
    #1;
    n_chk++;
    if (obs !== ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0)) begin
      n_fail++; $display("FAIL reset_idle got %h exp 0", obs);
    end
  endtask

  task automatic test_mvi;
    IR = 9'b001_010_000; Run = 1'b1;
    #1;
    n_chk++;
    if (obs !== ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0)) begin
      n_fail++; $display("FAIL mvi_T0 got %h exp %h", obs, ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0));
    end
    tick(); Run = 1'b0; #1;
    n_chk++;
    if (obs !== ex(0, 8'b00100000, 8'h00, 1, 0, 0, 0, 0, 1, 2'd1)) begin
      n_fail++; $display("FAIL mvi_T1 got %h exp %h", obs, ex(0, 8'b00100000, 8'h00, 1, 0, 0, 0, 0, 1, 2'd1));
    end
    tick(); #1;
    n_chk++;
    if (obs !== ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0)) begin
      n_fail++; $display("FAIL mvi_back_T0 got %h exp 0", obs);
    end
  endtask

  task automatic test_add;
    IR = 9'b010_001_101; Run = 1'b1; #1;
    n_chk++;
    if (obs !== ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0)) begin
      n_fail++; $display("FAIL add_T0 got %h", obs);
    end
    tick(); Run = 1'b0; #1;
    n_chk++;
    if (obs !== ex(0, 8'h00, 8'b01000000, 0, 0, 1, 0, 0, 0, 2'd1)) begin
      n_fail++; $display("FAIL add_T1 got %h exp %h", obs, ex(0, 8'h00, 8'b01000000, 0, 0, 1, 0, 0, 0, 2'd1));
    end
    tick(); #1;
    n_chk++;
    if (obs !== ex(0, 8'h00, 8'b00000100, 0, 0, 0, 1, 0, 0, 2'd2)) begin
      n_fail++; $display("FAIL add_T2 got %h exp %h", obs, ex(0, 8'h00, 8'b00000100, 0, 0, 0, 1, 0, 0, 2'd2));
    end
    tick(); #1;
    n_chk++;
    if (obs !== ex(0, 8'b01000000, 8'h00, 0, 1, 0, 0, 0, 1, 2'd3)) begin
      n_fail++; $display("FAIL add_T3 got %h exp %h", obs, ex(0, 8'b01000000, 8'h00, 0, 1, 0, 0, 0, 1, 2'd3));
    end
    tick(); #1;
  endtask

  task automatic test_sub_same_reg;
    int lat;
    IR = 9'b011_111_111; Run = 1'b1;
    tick(); Run = 1'b0; #1;
    n_chk++;
    if (obs !== ex(0, 8'h00, 8'b00000001, 0, 0, 1, 0, 0, 0, 2'd1)) begin
      n_fail++; $display("FAIL sub_T1 got %h exp %h", obs, ex(0, 8'h00, 8'b00000001, 0, 0, 1, 0, 0, 0, 2'd1));
    end
    tick(); #1;
    n_chk++;
    if (obs !== ex(0, 8'h00, 8'b00000001, 0, 0, 0, 1, 1, 0, 2'd2)) begin
      n_fail++; $display("FAIL sub_T2 got %h exp %h", obs, ex(0, 8'h00, 8'b00000001, 0, 0, 0, 1, 1, 0, 2'd2));
    end
    tick(); #1;
    n_chk++;
    if (obs !== ex(0, 8'b00000001, 8'h00, 0, 1, 0, 0, 0, 1, 2'd3)) begin
      n_fail++; $display("FAIL sub_T3 got %h exp %h", obs, ex(0, 8'b00000001, 8'h00, 0, 1, 0, 0, 0, 1, 2'd3));
    end
    tick(); #1;
    // Latency: Run cycle counts as cycle 1, Done expected on cycle 4.
    Run = 1'b1; lat = 1; #1;
    tick(); Run = 1'b0; #1;
    lat++;
    while (Done !== 1'b1 && lat < 10) begin
      tick(); #1; lat++;
    end
    n_chk++;
    if (lat !== 4) begin
      n_fail++; $display("FAIL sub_latency got %0d cycles exp 4", lat);
    end
    tick(); #1;
  endtask

  task automatic test_back_to_back;
    IR = 9'b110_000_000; Run = 1'b1; #1;
    tick(); #1;
    n_chk++;
    if (obs !== ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 2'd1)) begin
      n_fail++; $display("FAIL illegal_T1 got %h exp %h", obs, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 2'd1));
    end
    tick(); IR = 9'b000_000_100; #1;
    n_chk++;
    if (obs !== ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0)) begin
      n_fail++; $display("FAIL b2b_T0 got %h exp %h", obs, ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0));
    end
    tick(); Run = 1'b0; #1;
    n_chk++;
    if (obs !== ex(0, 8'b10000000, 8'b00001000, 0, 0, 0, 0, 0, 1, 2'd1)) begin
      n_fail++; $display("FAIL mv_T1 got %h exp %h", obs, ex(0, 8'b10000000, 8'b00001000, 0, 0, 0, 0, 0, 1, 2'd1));
    end
    tick(); #1;
  endtask

  task automatic test_ir_change;
    IR = 9'b010_011_100; Run = 1'b1;
    tick(); Run = 1'b0;
    tick(); IR = 9'b000_011_100; #1;
    n_chk++;
    if (obs !== ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd2)) begin
      n_fail++; $display("FAIL irchg_T2 got %h exp %h", obs, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd2));
    end
    tick(); #1;
    n_chk++;
    if (obs !== ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0)) begin
      n_fail++; $display("FAIL irchg_back_T0 got %h exp 0", obs);
    end
  endtask

  task automatic test_reset_mid;
    IR = 9'b010_001_101; Run = 1'b1;
    tick(); Run = 1'b0;
    tick(); Resetn = 1'b0; Run = 1'b1; #1;
    n_chk++;
    if (obs !== ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd2)) begin
      n_fail++; $display("FAIL rstmid_T2 got %h exp %h", obs, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd2));
    end
    tick(); #1;
    n_chk++;
    if (obs !== ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0)) begin
      n_fail++; $display("FAIL rstmid_abort got %h exp 0", obs);
    end
    Resetn = 1'b1; Run = 1'b0;
    tick(); #1;
    n_chk++;
    if (obs !== ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0)) begin
      n_fail++; $display("FAIL rstmid_after got %h exp 0", obs);
    end
  endtask

  initial begin
    Resetn = 1'b0; Run = 1'b0; IR = '0;
    test_reset();
    test_mvi();
    test_add();
    test_sub_same_reg();
    test_back_to_back();
    test_ir_change();
    test_reset_mid();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
